// File: rtl/eval_stack_engine_if.sv
// Command channel between the parser control FSM and the evaluation stack engine.
// The parser drives op/data under a valid/ready handshake; the engine returns ready.
interface eval_stack_engine_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/eval_stack_engine.sv
// Operand stack plus ALU for the expression evaluator, with an iterative restoring
// divider for DIV/MOD, sticky error flags and occupancy status.
module eval_stack_engine #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  eval_stack_engine_if.slave cmd,
  output logic [WIDTH-1:0]   top_data,
  output logic [CNT_W-1:0]   depth,
  output logic               is_empty,
  output logic               is_full,
  output logic               busy,
  output logic               op_done,
  output logic               err_underflow,
  output logic               err_overflow,
  output logic               err_div0
);

  localparam int AW     = $clog2(DEPTH);
  localparam int ITER_W = $clog2(WIDTH);

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_DIV  = 3'd4;
  localparam logic [2:0] OP_MOD  = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(WIDTH - 1);

  logic [WIDTH-1:0]  stack_mem [DEPTH];
  logic [1:0]        state;
  logic [CNT_W-1:0]  depth_q;
  logic [CNT_W-1:0]  depth_m1;
  logic [CNT_W-1:0]  depth_m2;
  logic [WIDTH-1:0]  operand_a;
  logic [WIDTH-1:0]  operand_b;
  logic [WIDTH-1:0]  alu_result;

  logic [WIDTH-1:0]  div_rem;
  logic [WIDTH-1:0]  div_quo;
  logic [WIDTH-1:0]  div_divisor;
  logic              div_is_mod;
  logic [ITER_W-1:0] div_iter;
  logic [WIDTH:0]    rem_shift;
  logic [WIDTH:0]    rem_trial;
  logic [WIDTH-1:0]  wb_result;

  logic accept;
  logic has_two;
  logic stack_full;
  logic op_binary;
  logic op_divide;
  logic push_ok;
  logic alu_ok;
  logic div_start;
  logic underflow_hit;
  logic overflow_hit;
  logic div0_hit;
  logic clr_hit;

  assign depth_m1   = depth_q - CNT_W'(1);
  assign depth_m2   = depth_q - CNT_W'(2);
  assign operand_b  = stack_mem[depth_m1[AW-1:0]];
  assign operand_a  = stack_mem[depth_m2[AW-1:0]];
  assign has_two    = (depth_q >= CNT_W'(2));
  assign stack_full = (depth_q == CNT_W'(DEPTH));

  assign cmd.cmd_ready = (state == ST_IDLE);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  assign depth    = depth_q;
  assign is_empty = (depth_q == '0);
  assign is_full  = stack_full;
  assign busy     = (state != ST_IDLE);
  assign top_data = (depth_q == '0) ? '0 : operand_b;

  // Command classification; error cases drop the command without touching the stack.
  always_comb begin
    op_binary     = (cmd.cmd_op >= OP_ADD) && (cmd.cmd_op <= OP_MOD);
    op_divide     = (cmd.cmd_op == OP_DIV) || (cmd.cmd_op == OP_MOD);
    push_ok       = accept && (cmd.cmd_op == OP_PUSH) && !stack_full;
    overflow_hit  = accept && (cmd.cmd_op == OP_PUSH) && stack_full;
    underflow_hit = accept && op_binary && !has_two;
    alu_ok        = accept && op_binary && !op_divide && has_two;
    div_start     = accept && op_divide && has_two && (operand_b != '0);
    div0_hit      = accept && op_divide && has_two && (operand_b == '0);
    clr_hit       = accept && (cmd.cmd_op == OP_CLR);
  end

  always_comb begin
    alu_result = '0;
    case (cmd.cmd_op)
      OP_ADD:  alu_result = operand_a + operand_b;
      OP_SUB:  alu_result = operand_a - operand_b;
      OP_MUL:  alu_result = operand_a * operand_b;
      default: alu_result = '0;
    endcase
  end

  // One restoring step: shift in the next dividend bit, keep the difference if non-negative.
  assign rem_shift = {div_rem, div_quo[WIDTH-1]};
  assign rem_trial = rem_shift - {1'b0, div_divisor};
  assign wb_result = div_is_mod ? div_rem : div_quo;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      depth_q       <= '0;
      op_done       <= 1'b0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
      err_div0      <= 1'b0;
      div_rem       <= '0;
      div_quo       <= '0;
      div_divisor   <= '0;
      div_is_mod    <= 1'b0;
      div_iter      <= '0;
    end else begin
      op_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (div_start) begin
              state       <= ST_DIV;
              div_iter    <= '0;
              div_rem     <= '0;
              div_quo     <= operand_a;
              div_divisor <= operand_b;
              div_is_mod  <= (cmd.cmd_op == OP_MOD);
            end else begin
              op_done <= 1'b1;
            end
          end
          if (push_ok) depth_q <= depth_q + CNT_W'(1);
          if (alu_ok)  depth_q <= depth_m1;
          if (clr_hit) begin
            depth_q       <= '0;
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
            err_div0      <= 1'b0;
          end else begin
            if (underflow_hit) err_underflow <= 1'b1;
            if (overflow_hit)  err_overflow  <= 1'b1;
            if (div0_hit)      err_div0      <= 1'b1;
          end
        end
        ST_DIV: begin
          if (!rem_trial[WIDTH]) begin
            div_rem <= rem_trial[WIDTH-1:0];
            div_quo <= {div_quo[WIDTH-2:0], 1'b1};
          end else begin
            div_rem <= rem_shift[WIDTH-1:0];
            div_quo <= {div_quo[WIDTH-2:0], 1'b0};
          end
          div_iter <= div_iter + ITER_W'(1);
          if (div_iter == ITER_LAST) state <= ST_WB;
        end
        ST_WB: begin
          depth_q <= depth_m1;
          op_done <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stack contents need no reset; only the depth pointer defines what is valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push_ok)
        stack_mem[depth_q[AW-1:0]] <= cmd.cmd_data;
      else if (alu_ok)
        stack_mem[depth_m2[AW-1:0]] <= alu_result;
      else if (state == ST_WB)
        stack_mem[depth_m2[AW-1:0]] <= wb_result;
    end
  end

endmodule

// File: tb/tb_eval_stack_engine.sv
// Directed bench for eval_stack_engine (WIDTH=8, DEPTH=16) with hand-computed expectations.
module tb_eval_stack_engine;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_DIV  = 3'd4;
  localparam logic [2:0] OP_MOD  = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;
  localparam logic [2:0] OP_NOP  = 3'd7;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] top_data;
  logic [CNT_W-1:0] depth;
  logic             is_empty;
  logic             is_full;
  logic             busy;
  logic             op_done;
  logic             err_underflow;
  logic             err_overflow;
  logic             err_div0;

  int checks   = 0;
  int failures = 0;
  int cycles;

  always #5 clk = ~clk;

  eval_stack_engine_if #(.WIDTH(WIDTH)) bus ();

  eval_stack_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd           (bus),
    .top_data      (top_data),
    .depth         (depth),
    .is_empty      (is_empty),
    .is_full       (is_full),
    .busy          (busy),
    .op_done       (op_done),
    .err_underflow (err_underflow),
    .err_overflow  (err_overflow),
    .err_div0      (err_div0)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      $error("[TB] check %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_stack(input string tag, input logic [31:0] exp_top,
                             input logic [31:0] exp_depth);
    check_output({tag, "_top"}, 32'(top_data), exp_top);
    check_output({tag, "_depth"}, 32'(depth), exp_depth);
  endtask

  // Offer one command across a single rising edge; returns 1ns after that edge.
  task automatic apply_stimulus(input logic [2:0] op, input logic [WIDTH-1:0] data);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.cmd_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_stack("reset", 0, 0);
    check_output("reset_ready", 32'(bus.cmd_ready), 1);
    check_output("reset_busy", 32'(busy), 0);
    check_output("reset_done", 32'(op_done), 0);
    check_output("reset_empty", 32'(is_empty), 1);
    check_output("reset_errs", {29'd0, err_underflow, err_overflow, err_div0}, 0);
    @(negedge clk);
    rst = 1'b0;

    // 7 - 3, then 4 + 250, then wrap 254 + 3
    apply_stimulus(OP_PUSH, 8'd7);
    apply_stimulus(OP_PUSH, 8'd3);
    apply_stimulus(OP_SUB, 8'hAA);
    check_stack("sub", 4, 1);
    check_output("sub_done", 32'(op_done), 1);
    apply_stimulus(OP_PUSH, 8'd250);
    apply_stimulus(OP_ADD, 8'h55);
    check_stack("add", 254, 1);
    apply_stimulus(OP_PUSH, 8'd3);
    apply_stimulus(OP_ADD, 8'd0);
    check_stack("add_wrap", 1, 1);
    apply_stimulus(OP_SUB, 8'd0);
    check_output("sub_depth1_uf", 32'(err_underflow), 1);
    check_stack("sub_depth1", 1, 1);
    apply_stimulus(OP_CLR, 8'd0);
    check_output("clr_done", 32'(op_done), 1);
    check_output("clr_uf", 32'(err_underflow), 0);

    // 100 / 7 through the iterative divider
    apply_stimulus(OP_PUSH, 8'd100);
    apply_stimulus(OP_PUSH, 8'd7);
    apply_stimulus(OP_DIV, 8'hFF);
    check_output("div_ready_low", 32'(bus.cmd_ready), 0);
    check_output("div_busy", 32'(busy), 1);
    check_stack("div_untouched", 7, 2);
    wait_ready(cycles);
    check_output("div_cycles", 32'(cycles), 9);
    check_output("div_done", 32'(op_done), 1);
    check_stack("div", 14, 1);
    @(posedge clk);
    #1;
    check_output("div_done_pulse", 32'(op_done), 0);

    apply_stimulus(OP_CLR, 8'd0);
    apply_stimulus(OP_PUSH, 8'd100);
    apply_stimulus(OP_PUSH, 8'd7);
    apply_stimulus(OP_MOD, 8'd0);
    wait_ready(cycles);
    check_output("mod_cycles", 32'(cycles), 9);
    check_stack("mod", 2, 1);

    apply_stimulus(OP_CLR, 8'd0);
    apply_stimulus(OP_PUSH, 8'd20);
    apply_stimulus(OP_PUSH, 8'd13);
    apply_stimulus(OP_MUL, 8'd9);
    check_stack("mul", 4, 1);

    apply_stimulus(OP_PUSH, 8'd200);
    apply_stimulus(OP_PUSH, 8'd3);
    apply_stimulus(OP_DIV, 8'd0);
    wait_ready(cycles);
    check_stack("div_200_3", 66, 2);
    apply_stimulus(OP_PUSH, 8'd9);
    apply_stimulus(OP_MOD, 8'd0);
    wait_ready(cycles);
    check_stack("mod_66_9", 3, 2);
    apply_stimulus(OP_MUL, 8'd0);
    check_stack("mul_4_3", 12, 1);

    // Error cases
    apply_stimulus(OP_CLR, 8'd0);
    apply_stimulus(OP_ADD, 8'd0);
    check_output("empty_add_uf", 32'(err_underflow), 1);
    check_output("empty_add_done", 32'(op_done), 1);
    check_stack("empty_add", 0, 0);
    apply_stimulus(OP_PUSH, 8'd5);
    apply_stimulus(OP_PUSH, 8'd0);
    apply_stimulus(OP_DIV, 8'd0);
    check_output("div0_flag", 32'(err_div0), 1);
    check_output("div0_ready", 32'(bus.cmd_ready), 1);
    check_output("div0_busy", 32'(busy), 0);
    check_output("div0_done", 32'(op_done), 1);
    check_stack("div0", 0, 2);
    check_output("div0_uf_sticky", 32'(err_underflow), 1);
    apply_stimulus(OP_CLR, 8'd0);
    check_output("clr_errs", {29'd0, err_underflow, err_overflow, err_div0}, 0);
    check_stack("clr", 0, 0);
    check_output("clr_empty", 32'(is_empty), 1);

    // Fill to DEPTH, then overflow
    for (int i = 1; i <= DEPTH; i++) begin
      apply_stimulus(OP_PUSH, WIDTH'(i));
      if (i == DEPTH - 1) check_output("almost_full", 32'(is_full), 0);
    end
    check_output("full", 32'(is_full), 1);
    check_stack("full", 16, 16);
    apply_stimulus(OP_PUSH, 8'd99);
    check_output("overflow_flag", 32'(err_overflow), 1);
    check_output("overflow_done", 32'(op_done), 1);
    check_stack("overflow", 16, 16);

    // Commands ignored while dividing, then reset mid-divide
    apply_stimulus(OP_CLR, 8'd0);
    apply_stimulus(OP_PUSH, 8'd200);
    apply_stimulus(OP_PUSH, 8'd3);
    apply_stimulus(OP_DIV, 8'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_PUSH;
    bus.cmd_data  = 8'd55;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_stack("busy_push", 3, 2);
      check_output("busy_ready", 32'(bus.cmd_ready), 0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    check_stack("mid_rst", 0, 0);
    check_output("mid_rst_ready", 32'(bus.cmd_ready), 1);
    check_output("mid_rst_busy", 32'(busy), 0);
    check_output("mid_rst_done", 32'(op_done), 0);
    @(posedge clk);
    #1;
    check_output("mid_rst_no_done", 32'(op_done), 0);
    check_stack("mid_rst_after", 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eval_stack_engine.md
Name: eval_stack_engine

Overview:
- Parametrised execution core for the calculator's expression evaluator: an operand stack of DEPTH x WIDTH entries plus an ALU.
- Commands arrive on a valid/ready handshake from the parser control FSM.
- Adds DIV/MOD through an integrated iterative restoring divider, with sticky error flags and occupancy status.
- Replaces the fixed 8-bit operand stack, op1/op2 registers and result register of the current datapath.

Parameters:
- WIDTH, 8, operand/result bit width (≥4).
- DEPTH, 16, operand stack entries (power of 2, ≥2).
- CNT_W, $clog2(DEPTH+1), width of depth count (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  engine can accept a command this cycle
- cmd_op  input  3  0=PUSH 1=ADD 2=SUB 3=MUL 4=DIV 5=MOD 6=CLR 7=NOP
- cmd_data  input  WIDTH  operand for PUSH
- top_data  output  WIDTH  top-of-stack value (0 when empty)
- depth  output  CNT_W  number of valid entries
- is_empty  output  1  depth==0
- is_full  output  1  depth==DEPTH
- busy  output  1  divider running or write-back pending
- op_done  output  1  one-cycle pulse when any accepted command completes (including rejected ones)
- err_underflow  output  1  sticky
- err_overflow  output  1  sticky
- err_div0  output  1  sticky

Behaviour:
- Reset (synchronous, on rst=1 at a clk edge, overrides everything including a running divide):
  - State IDLE; depth=0; stack contents don't-care; top_data=0.
  - cmd_ready=1, busy=0, op_done=0, all err flags 0.
- Handshake: a command is accepted on an edge where cmd_valid&&cmd_ready. cmd_ready = (state==IDLE). cmd_valid while not ready is ignored; no queueing.
- Operand convention: binary ops take b = top, a = entry below top; result = a op b replaces both entries (depth-1).
- All arithmetic is unsigned modulo 2^WIDTH:
  - SUB wraps.
  - MUL keeps the low WIDTH bits of the 2*WIDTH product.
- PUSH/CLR/NOP and ADD/SUB/MUL complete at the accepting edge; the new top/depth are visible the following cycle, and op_done pulses that cycle.
- CLR: depth=0 and all three err flags cleared.
- DIV/MOD, depth≥2, b≠0:
  - Accept edge latches a, b, op, pops nothing yet; enters DIV.
  - DIV runs WIDTH iterations (one quotient bit per clk, restoring).
  - Then one WB cycle writes quotient (DIV) or remainder (MOD), depth-1.
  - cmd_ready is low for exactly WIDTH+1 cycles after acceptance; op_done pulses in the cycle after WB; cmd_ready returns high in that same cycle.
  - Stack contents are untouched until WB.
- Error rules (command dropped, stack unchanged, flag set at the accepting edge, op_done pulses next cycle, no DIV entry):
  - Binary op with depth<2 -> err_underflow.
  - PUSH with depth==DEPTH -> err_overflow.
  - DIV/MOD with b==0 and depth≥2 -> err_div0.
- Flags stay set until CLR or rst. Commands continue to execute while flags are set.
- FSM: IDLE -(accepted DIV/MOD, valid)-> DIV -(iteration WIDTH done)-> WB -> IDLE. All other commands stay in IDLE.
- Boundaries:
  - PUSH at depth DEPTH-1 succeeds and raises is_full.
  - A binary op at depth 2 leaves depth 1.
  - top_data is driven from the register file indexed by depth-1, combinationally from state.
- Results must be independent of the cmd_data value for non-PUSH ops.

Test Plan:
- PUSH 7, PUSH 3, SUB -> top_data=4, depth=1; then PUSH 250, ADD with WIDTH=8 -> top_data=254; PUSH 3, ADD -> top_data=1 (wrap).
- PUSH 100, PUSH 7, DIV -> cmd_ready low 9 cycles (WIDTH=8), op_done on cycle 10, top_data=14, depth=1; repeat with MOD -> 2. PUSH 20, PUSH 13, MUL -> 260 mod 256 = 4.
- Empty stack: ADD -> err_underflow=1, depth=0. PUSH 5, PUSH 0, DIV -> err_div0=1, depth=2, top_data=0. CLR -> all flags 0, depth=0, is_empty=1.
- DEPTH=16: 16 PUSHes of 1..16 -> is_full=1, top_data=16; 17th PUSH 99 -> err_overflow=1, top_data=16, depth=16.
- Start DIV 200/3, assert cmd_valid with PUSH every cycle during busy -> no PUSH accepted; assert rst on the 4th DIV cycle -> next cycle depth=0, cmd_ready=1, busy=0, no op_done.
